bf_stage_ctrl: RTL

Control sequencer for one radix-2 single-path delay-feedback butterfly stage: input demux, delay line, add/sub, sub-save delay line, output mux, twiddle multiplier. From a per-beat `valid_in` it generates the input-switch, output-switch and twiddle-select controls, plus the stage output enable and frame status pulses. It replaces hand-tuned compare chains with parameterised, overlap-safe sequencing. Back-to-back frames stream without bubbles.

---
 rtl/bf_ctrl_pkg.sv | 34 +++
 rtl/bf_ctrl_out_seq.sv | 131 +++++++++++++
 rtl/bf_stage_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/bf_ctrl_pkg.sv
// Shared types and helpers for the butterfly-stage control sequencer.
// Holds the input/output FSM state encodings and the derived-width helpers.
package bf_ctrl_pkg;

    typedef enum logic {
        IN_IDLE,
        IN_RECV
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_WAIT,
        OUT_RUN
    } out_state_e;

    localparam int DEF_DELAY       = 8;
    localparam int DEF_FRAME_BEATS = 32;
    localparam int DEF_ADD_LAT     = 1;
    localparam int DEF_FAC_STEP    = 4;
    localparam int DEF_FAC_W       = 3;

    // Frame cycle 0 to first output beat: delay line plus add/sub register stages.
    localparam int DEF_L = DEF_DELAY + DEF_ADD_LAT;

    // Width of a counter holding 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lat_total(input int delay, input int add_lat);
        return delay + add_lat;
    endfunction

endpackage

// File: rtl/bf_ctrl_out_seq.sv
// Output-side sequencer: waits L cycles after each frame start, then runs the
// output index j, driving o_en/out_sw/fac_sel/frm_done. Holds one pending frame.
module bf_ctrl_out_seq
    import bf_ctrl_pkg::*;
#(
    parameter int DELAY       = DEF_DELAY,
    parameter int FRAME_BEATS = DEF_FRAME_BEATS,
    parameter int ADD_LAT     = DEF_ADD_LAT,
    parameter int FAC_STEP    = DEF_FAC_STEP,
    parameter int FAC_W       = DEF_FAC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic             flush_i,
    output logic             o_en_o,
    output logic             out_sw_o,
    output logic [FAC_W-1:0] fac_sel_o,
    output logic             frm_done_o,
    output logic             busy_o
);

    localparam int L       = lat_total(DELAY, ADD_LAT);
    localparam int J_W     = cnt_w(FRAME_BEATS);
    localparam int W_W     = cnt_w(L);
    localparam int D_SHIFT = $clog2(DELAY);
    localparam int F_SHIFT = $clog2(FAC_STEP);

    localparam logic [J_W-1:0] J_LAST = J_W'(FRAME_BEATS - 1);
    localparam logic [W_W-1:0] W_INIT = W_W'(L - 1);

    out_state_e     state_q, state_d;
    logic [J_W-1:0] j_q, j_d;
    logic [W_W-1:0] w_q, w_d;
    logic           pend_q, pend_d;
    logic [W_W-1:0] pcnt_q, pcnt_d;
    logic           run;

    logic             o_en_q, out_sw_q, frm_done_q;
    logic [FAC_W-1:0] fac_sel_q;

    assign run = (state_q == OUT_RUN);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        j_d     = j_q;
        w_d     = w_q;
        pend_d  = pend_q;
        pcnt_d  = pend_q ? pcnt_q - 1 : pcnt_q;

        case (state_q)
            OUT_IDLE: begin
                if (start_i) begin
                    state_d = OUT_WAIT;
                    w_d     = W_INIT;
                end
            end
            OUT_WAIT: begin
                if (w_q == 1) begin
                    state_d = OUT_RUN;
                    j_d     = '0;
                end else begin
                    w_d = w_q - 1;
                end
            end
            OUT_RUN: begin
                if (j_q != J_LAST) begin
                    j_d = j_q + 1;
                    if (start_i) begin
                        pend_d = 1'b1;
                        pcnt_d = W_INIT;
                    end
                end else begin
                    // pcnt_q counts cycles until the pending frame's first output beat.
                    j_d    = '0;
                    pend_d = 1'b0;
                    if (start_i) begin
                        state_d = OUT_WAIT;
                        w_d     = W_INIT;
                    end else if (pend_q && pcnt_q == 1) begin
                        state_d = OUT_RUN;
                    end else if (pend_q) begin
                        state_d = OUT_WAIT;
                        w_d     = pcnt_q - 1;
                    end else begin
                        state_d = OUT_IDLE;
                    end
                end
            end
            default: state_d = OUT_IDLE;
        endcase

        if (flush_i) begin
            state_d = OUT_IDLE;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= OUT_IDLE;
            j_q        <= '0;
            w_q        <= '0;
            pend_q     <= 1'b0;
            pcnt_q     <= '0;
            o_en_q     <= 1'b0;
            out_sw_q   <= 1'b0;
            fac_sel_q  <= '0;
            frm_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= state_d;
            j_q        <= j_d;
            w_q        <= w_d;
            pend_q     <= pend_d;
            pcnt_q     <= pcnt_d;
            o_en_q     <= run;
            out_sw_q   <= run & j_q[D_SHIFT];
            fac_sel_q  <= run ? FAC_W'(j_q >> F_SHIFT) : '0;
            frm_done_q <= run && (j_q == J_LAST);
        end
    end

    assign o_en_o     = o_en_q;
    assign out_sw_o   = out_sw_q;
    assign fac_sel_o  = fac_sel_q;
    assign frm_done_o = frm_done_q;
    assign busy_o     = (state_q != OUT_IDLE);

endmodule

// File: rtl/bf_stage_ctrl.sv
// Control sequencer for one radix-2 SDF butterfly stage (input FSM, in_sw, frame status).
// Define BF_STAGE_CTRL_ERR_EN to enable abort detection on a mid-frame valid_in drop.
module bf_stage_ctrl
    import bf_ctrl_pkg::*;
#(
    parameter int DELAY       = DEF_DELAY,
    parameter int FRAME_BEATS = DEF_FRAME_BEATS,
    parameter int ADD_LAT     = DEF_ADD_LAT,
    parameter int FAC_STEP    = DEF_FAC_STEP,
    parameter int FAC_W       = DEF_FAC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    output logic             in_sw,
    output logic             out_sw,
    output logic [FAC_W-1:0] fac_sel,
    output logic             o_en,
    output logic             frm_start,
    output logic             frm_done,
    output logic             busy,
    output logic             err
);

    localparam int K_W     = cnt_w(FRAME_BEATS);
    localparam int D_SHIFT = $clog2(DELAY);

    localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_BEATS - 1);

    in_state_e      in_state_q, in_state_d;
    logic [K_W-1:0] k_q, k_d, k_cur;
    logic           start, active, last_beat, abort, out_busy;
    logic           in_sw_q, frm_start_q, busy_q;

    always_comb begin
        start      = (in_state_q == IN_IDLE) && valid_in;
        active     = start || (in_state_q == IN_RECV);
        k_cur      = start ? '0 : k_q;
        last_beat  = active && (k_cur == K_LAST);
        in_state_d = IN_IDLE;
        k_d        = '0;
        // After the last beat the FSM drops to IDLE, where a valid beat is the next frame's beat 0.
        if (!abort && active && !last_beat) begin
            in_state_d = IN_RECV;
            k_d        = k_cur + 1;
        end
    end

`ifdef BF_STAGE_CTRL_ERR_EN
    logic abort_q, err_q;

    assign abort = (in_state_q == IN_RECV) && !valid_in && (k_q != K_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            abort_q <= abort;
            err_q   <= abort_q;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_state_q  <= IN_IDLE;
            k_q         <= '0;
            in_sw_q     <= 1'b0;
            frm_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            k_q         <= k_d;
            in_sw_q     <= active & k_cur[D_SHIFT];
            frm_start_q <= start;
            busy_q      <= active | out_busy;
        end
    end

    bf_ctrl_out_seq #(
        .DELAY       (DELAY),
        .FRAME_BEATS (FRAME_BEATS),
        .ADD_LAT     (ADD_LAT),
        .FAC_STEP    (FAC_STEP),
        .FAC_W       (FAC_W)
    ) u_out_seq (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start),
        .flush_i    (abort),
        .o_en_o     (o_en),
        .out_sw_o   (out_sw),
        .fac_sel_o  (fac_sel),
        .frm_done_o (frm_done),
        .busy_o     (out_busy)
    );

    assign in_sw     = in_sw_q;
    assign frm_start = frm_start_q;
    assign busy      = busy_q;

endmodule
